// File: rtl/main_fsm_pkg.sv
// Shared encodings for the multicycle controller and datapath.
// State codes and mux select constants.
package main_fsm_pkg;

    localparam int STATE_W = 4;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t FETCH    = 4'd0;
    localparam state_t DECODE   = 4'd1;
    localparam state_t MEMADR   = 4'd2;
    localparam state_t MEMREAD  = 4'd3;
    localparam state_t MEMWB    = 4'd4;
    localparam state_t MEMWRITE = 4'd5;
    localparam state_t EXECUTER = 4'd6;
    localparam state_t EXECUTEI = 4'd7;
    localparam state_t ALUWB    = 4'd8;
    localparam state_t BRANCH   = 4'd9;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/main_fsm_statereg.sv
// State register for the multicycle controller.
// Asynchronous active-high reset to FETCH.
module main_fsm_statereg
    import main_fsm_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  state_t d,
    output state_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= FETCH;
        else     q <= d;
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle main controller: next-state and Moore-style control outputs.
// Only IRWrite/NextPC (FETCH) and Illegal (DECODE) look at live inputs.
module main_fsm
    import main_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ALUOp,
    output logic [1:0] ResultSrc,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t nxt;
    logic   funct_unused;

    assign funct_unused = ^Funct[4:1];

    main_fsm_statereg statereg (
        .clk (clk),
        .rst (rst),
        .d   (nxt),
        .q   (State)
    );

    always_comb begin
        nxt       = FETCH;
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_REG;
        ALUOp     = 1'b0;
        ResultSrc = RES_ALUOUT;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        Illegal   = 1'b0;
        unique case (State)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = MemReady;
                NextPC    = MemReady;
                nxt       = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (Op)
                    2'b00: nxt = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01: nxt = MEMADR;
                    2'b10: nxt = BRANCH;
                    2'b11: begin
                        Illegal = 1'b1;
                        nxt     = FETCH;
                    end
                    default: nxt = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcB = SRCB_IMM;
                nxt     = Funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                nxt    = MemReady ? MEMWB : MEMREAD;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
                nxt    = MemReady ? FETCH : MEMWRITE;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegW      = 1'b1;
            end
            EXECUTER: begin
                ALUOp = 1'b1;
                nxt   = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                ALUOp   = 1'b1;
                nxt     = ALUWB;
            end
            ALUWB: begin
                RegW = 1'b1;
            end
            BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                Branch    = 1'b1;
            end
            default: nxt = FETCH;
        endcase
    end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL expose these ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- Op  in  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 illegal
- Funct  in  6  instruction bits [25:20]; Funct[5]=I (immediate), Funct[0]=S for data-processing, L for memory
- MemReady  in  1  memory completes the current access this cycle
- IRWrite  out  1  load instruction register
- NextPC  out  1  load PC with Result
- AdrSrc  out  1  memory address select: 0 PC, 1 Result
- ALUSrcA  out  1  ALU operand A select: 0 register A, 1 PC
- ALUSrcB  out  2  ALU operand B select: 00 register B, 01 extended immediate, 10 constant 4
- ALUOp  out  1  1 = ALU decoder uses Funct; 0 = add
- ResultSrc  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult
- RegW  out  1  unconditioned register write; the condition-gating stage qualifies it with CondEx
- MemW  out  1  unconditioned memory write; qualified downstream
- Branch  out  1  unconditioned branch; qualified downstream
- Illegal  out  1  one-cycle pulse on decode of Op=11
- State  out  4  current state encoding, for debug

Function
REQ-002 The block SHALL be a multicycle controller with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9; encodings 10-15 are unused.
REQ-003 FETCH SHALL drive AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10, and IRWrite=NextPC=MemReady; it SHALL stay in FETCH while MemReady=0 and go to DECODE when MemReady=1.
REQ-004 DECODE SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10 and SHALL transition as follows:
- Op=01 to MEMADR
- Op=00 with Funct[5]=0 to EXECUTER
- Op=00 with Funct[5]=1 to EXECUTEI
- Op=10 to BRANCH
- Op=11 to FETCH, with Illegal=1 for that cycle
REQ-005 MEMADR SHALL drive ALUSrcA=0, ALUSrcB=01, ALUOp=0, then go to MEMREAD if Funct[0]=1, otherwise to MEMWRITE.
REQ-006 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00; it SHALL hold while MemReady=0 and go to MEMWB when MemReady=1.
REQ-007 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00, MemW=1 on every cycle in the state; it SHALL hold while MemReady=0 and go to FETCH when MemReady=1.
REQ-008 MEMWB SHALL drive ResultSrc=01, RegW=1 for exactly one cycle, then go to FETCH.
REQ-009 EXECUTER SHALL drive ALUSrcA=0, ALUSrcB=00, ALUOp=1; EXECUTEI SHALL drive ALUSrcA=0, ALUSrcB=01, ALUOp=1; both SHALL go to ALUWB.
REQ-010 ALUWB SHALL drive ResultSrc=00, RegW=1 for one cycle, then go to FETCH.
REQ-011 BRANCH SHALL drive ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1 for one cycle, then go to FETCH.
REQ-012 Any output not listed for a state SHALL be 0; RegW, MemW, Branch, IRWrite, NextPC and Illegal SHALL never be 1 outside the states named above.
REQ-013 Outputs SHALL be combinational from State (and MemReady in FETCH only); State SHALL be registered; Op, Funct and MemReady SHALL be sampled only on the transitions given above.
REQ-014 An unused State encoding SHALL drive all-zero outputs and go to FETCH on the next edge.
REQ-015 Latencies (cycles FETCH to FETCH, MemReady=1 throughout) SHALL be: load 5, store 4, data-processing 4, branch 3, illegal 2.

Reset
REQ-016 rst=1 SHALL force State=FETCH asynchronously; while rst is held, outputs SHALL follow the FETCH row, with RegW=MemW=Branch=Illegal=0.
REQ-017 Reset asserted mid-instruction (including mid-wait in MEMREAD or MEMWRITE) SHALL abandon the instruction; the first edge after release SHALL evaluate FETCH.

Structure
REQ-018 The state enum, its 4-bit width, and the ALUSrcB and ResultSrc select constants SHALL live in a shared package imported by the controller and the datapath.
REQ-019 The state register SHALL be one sub-module instance, statereg (async-reset flop, reset value FETCH); next-state and output logic SHALL be local to the block.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then MemReady=1, Op=00, Funct=000000: State 0,1,6,8,0; RegW=1 only in ALUWB; ALUOp=1 in EXECUTER.
- Load (Op=01, Funct[0]=1) with MemReady=0 for 3 cycles in MEMREAD: State sequence 0,1,2,3,3,3,3,4,0; RegW=1 for exactly one cycle, in MEMWB.
- Store (Op=01, Funct[0]=0) with 2 wait cycles: MemW=1 for 3 consecutive cycles, then State=0.
- FETCH with MemReady=0 for 2 cycles: IRWrite=NextPC=0 while waiting; pulse 1 on the MemReady=1 cycle.
- Op=11: Illegal=1 in DECODE for one cycle, next State=0, with no RegW, MemW or Branch.
- rst asserted in MEMWRITE wait: State=0 immediately and MemW drops to 0 without waiting for a clock edge.
